l15_responder: RTL and testbench

//  Memory-backed responder for the core's transducer_l15 request/response interface: sits on the
//  L1.5 side of the core's single arbitrated port. Accepts one instruction-fill, load or store

---
 rtl/l15_resp_pkg.sv | 42 ++++
 rtl/l15_resp_mem.sv | 34 +++
 rtl/l15_responder.sv | 169 ++++++++++++++++
 tb/tb_l15_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_resp_pkg.sv
// Shared encodings for the L1.5 responder: request/response types, size codes, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package l15_resp_pkg;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_IMISS = 5'b10000;
  localparam logic [4:0] RQ_STORE = 5'b00001;

  localparam logic [3:0] RT_LOAD_RET  = 4'b0000;
  localparam logic [3:0] RT_IFILL_RET = 4'b0001;
  localparam logic [3:0] RT_ST_ACK    = 4'b0100;
  localparam logic [3:0] RT_ERR       = 4'b1100;
  localparam logic [3:0] RT_UNSUP     = 4'b1111;

  localparam logic [2:0] SZ_B    = 3'd0;
  localparam logic [2:0] SZ_H    = 3'd1;
  localparam logic [2:0] SZ_W    = 3'd2;
  localparam logic [2:0] SZ_DW   = 3'd3;
  localparam logic [2:0] SZ_LINE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Byte enables for a store starting at byte lane 'lane'. The shift stays in
  // 8 bits, so a run that would pass lane 7 is clipped instead of wrapping.
  function automatic logic [7:0] byte_en(input logic [2:0] size, input logic [2:0] lane);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Single-port 64-bit SRAM bank with per-byte write enables.
// Latency: read data registered, valid the cycle after i_en with i_we=0; holds until next read.
// Backpressure: none; accepts one access per enabled cycle.
module l15_resp_mem #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [7:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [0:(1<<AW)-1];
  logic [63:0] r_rdata;

  // Byte-masked write, or registered read of the addressed word
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 8; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/l15_responder.sv
// Memory-backed L1.5 responder: one fill/load/store at a time from even/odd 64-bit SRAM banks.
// Latency: val sampled cycle N -> header_ack N+1 -> response val N+2+LATENCY. Optional L15_RESP_ERR_EN.
// Backpressure: new requests wait (no header_ack) until the held response is taken with req_ack.
module l15_responder
  import l15_resp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int ADDR_W    = 40
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [4:0]        transducer_l15_rqtype,
  input  logic [2:0]        transducer_l15_size,
  input  logic [ADDR_W-1:0] transducer_l15_address,
  input  logic [63:0]       transducer_l15_data,
  input  logic              transducer_l15_val,
  output logic              l15_transducer_header_ack,
  output logic              l15_transducer_ack,
  output logic              l15_transducer_val,
  output logic [3:0]        l15_transducer_returntype,
  output logic [63:0]       l15_transducer_data_0,
  output logic [63:0]       l15_transducer_data_1,
  input  logic              transducer_l15_req_ack
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BAW   = (IDX_W > 1) ? IDX_W - 1 : 1;
  localparam logic [3:0] LAT_LAST = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  state_t            r_state, w_next;
  logic [4:0]        r_rqtype;
  logic [2:0]        r_size;
  logic [IDX_W+2:0]  r_addr;
  logic [63:0]       r_data;
  logic [3:0]        r_cnt;

  logic              w_oor;
  logic [3:0]        w_rtype;
  logic              w_is_read, w_is_store;
  logic              w_accept, w_odd;
  logic [BAW-1:0]    w_bank_addr;
  logic [7:0]        w_be;
  logic [63:0]       w_rd_even, w_rd_odd;

`ifdef L15_RESP_ERR_EN
  logic r_oor;
  assign w_oor = r_oor;
`else
  logic w_addr_hi_unused;
  assign w_addr_hi_unused = |transducer_l15_address[ADDR_W-1:IDX_W+3];
  assign w_oor = 1'b0;
`endif

  // Word index bit 0 selects the bank; the rest addresses the line within the bank
  if (IDX_W > 1) begin : g_bank_addr
    assign w_bank_addr = r_addr[IDX_W+2:4];
  end else begin : g_bank_addr_one
    assign w_bank_addr = 1'b0;
  end

  assign w_odd    = r_addr[3];
  assign w_accept = (r_state == ST_ACCEPT);
  assign w_be     = byte_en(r_size, r_addr[2:0]);

  // Decode the captured request into a response type and the SRAM operation it needs
  always_comb begin
    w_rtype    = RT_UNSUP;
    w_is_read  = 1'b0;
    w_is_store = 1'b0;
    if (w_oor) begin
      w_rtype = RT_ERR;
    end else begin
      case (r_rqtype)
        RQ_LOAD:  begin w_rtype = RT_LOAD_RET;  w_is_read  = 1'b1; end
        RQ_IMISS: begin w_rtype = RT_IFILL_RET; w_is_read  = 1'b1; end
        RQ_STORE: begin w_rtype = RT_ST_ACK;    w_is_store = 1'b1; end
        default:  w_rtype = RT_UNSUP;
      endcase
    end
  end

  l15_resp_mem #(.AW(BAW)) u_mem_even (
    .clk     (clk),
    .i_en    (w_accept & (w_is_read | (w_is_store & ~w_odd))),
    .i_we    (w_is_store),
    .i_be    (w_be),
    .i_addr  (w_bank_addr),
    .i_wdata (r_data),
    .o_rdata (w_rd_even)
  );

  l15_resp_mem #(.AW(BAW)) u_mem_odd (
    .clk     (clk),
    .i_en    (w_accept & (w_is_read | (w_is_store & w_odd))),
    .i_we    (w_is_store),
    .i_be    (w_be),
    .i_addr  (w_bank_addr),
    .i_wdata (r_data),
    .o_rdata (w_rd_odd)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and state-decoded outputs; everything is zero outside ACCEPT/RESP
  always_comb begin
    w_next                    = r_state;
    l15_transducer_header_ack = 1'b0;
    l15_transducer_ack        = 1'b0;
    l15_transducer_val        = 1'b0;
    l15_transducer_returntype = 4'b0000;
    l15_transducer_data_0     = 64'd0;
    l15_transducer_data_1     = 64'd0;
    case (r_state)
      ST_IDLE: begin
        if (transducer_l15_val) w_next = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        l15_transducer_header_ack = 1'b1;
        l15_transducer_ack        = 1'b1;
        w_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == LAT_LAST) w_next = ST_RESP;
      end
      ST_RESP: begin
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = w_rtype;
        if (w_is_read) begin
          l15_transducer_data_0 = w_rd_even;
          l15_transducer_data_1 = w_rd_odd;
        end
        if (transducer_l15_req_ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request when leaving IDLE; count latency cycles while in WAIT
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rqtype <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
`ifdef L15_RESP_ERR_EN
      r_oor    <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && transducer_l15_val) begin
        r_rqtype <= transducer_l15_rqtype;
        r_size   <= transducer_l15_size;
        r_addr   <= transducer_l15_address[IDX_W+2:0];
        r_data   <= transducer_l15_data;
`ifdef L15_RESP_ERR_EN
        r_oor    <= |transducer_l15_address[ADDR_W-1:IDX_W+3];
`endif
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt + 4'd1;
      else                    r_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_l15_responder.sv
// Bench for l15_responder: vector table, hand-written corner sequences, randomized traffic vs a word-array model.
// Latency: checks header_ack at N+1 and response val at N+2+LATENCY on LATENCY=2 and LATENCY=0 instances.
// Backpressure: holds req_ack low in RESP and checks a queued request is not accepted early.
module tb_l15_responder;
  import l15_resp_pkg::*;

  localparam int MW    = 1024;
  localparam int HI_SH = $clog2(MW) + 3;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
`ifdef L15_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic [4:0]  rq   = '0;
  logic [2:0]  sz   = '0;
  logic [39:0] addr = '0;
  logic [63:0] wd   = '0;
  logic        val_a = 1'b0, val_b = 1'b0, rack_a = 1'b0, rack_b = 1'b0;
  logic        hack_a, ack_a, rv_a, hack_b, ack_b, rv_b;
  logic [3:0]  rt_a, rt_b;
  logic [63:0] d0_a, d1_a, d0_b, d1_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l15_responder #(.MEM_WORDS(MW), .LATENCY(LAT_A), .ADDR_W(40)) u_dut_a (
    .clk(clk), .nrst(nrst),
    .transducer_l15_rqtype(rq), .transducer_l15_size(sz),
    .transducer_l15_address(addr), .transducer_l15_data(wd),
    .transducer_l15_val(val_a),
    .l15_transducer_header_ack(hack_a), .l15_transducer_ack(ack_a),
    .l15_transducer_val(rv_a), .l15_transducer_returntype(rt_a),
    .l15_transducer_data_0(d0_a), .l15_transducer_data_1(d1_a),
    .transducer_l15_req_ack(rack_a)
  );

  l15_responder #(.MEM_WORDS(MW), .LATENCY(LAT_B), .ADDR_W(40)) u_dut_b (
    .clk(clk), .nrst(nrst),
    .transducer_l15_rqtype(rq), .transducer_l15_size(sz),
    .transducer_l15_address(addr), .transducer_l15_data(wd),
    .transducer_l15_val(val_b),
    .l15_transducer_header_ack(hack_b), .l15_transducer_ack(ack_b),
    .l15_transducer_val(rv_b), .l15_transducer_returntype(rt_b),
    .l15_transducer_data_0(d0_b), .l15_transducer_data_1(d1_b),
    .transducer_l15_req_ack(rack_b)
  );

  typedef struct {
    int          sel;
    logic [4:0]  q;
    logic [2:0]  s;
    logic [39:0] a;
    logic [63:0] d;
    logic [3:0]  rt;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t tbl[$];
  logic [63:0] mdl [0:MW-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic hk, output logic ak, output logic v,
                         output logic [3:0] rt, output logic [63:0] d0, output logic [63:0] d1);
    if (sel == 0) begin hk = hack_a; ak = ack_a; v = rv_a; rt = rt_a; d0 = d0_a; d1 = d1_a; end
    else          begin hk = hack_b; ak = ack_b; v = rv_b; rt = rt_b; d0 = d0_b; d1 = d1_b; end
  endtask

  task automatic set_val(input int sel, input logic v);
    if (sel == 0) val_a = v; else val_b = v;
  endtask

  task automatic set_rack(input int sel, input logic v);
    if (sel == 0) rack_a = v; else rack_b = v;
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check_idle(input int sel, input string nm);
    logic hk, ak, v; logic [3:0] rt; logic [63:0] d0, d1;
    get_out(sel, hk, ak, v, rt, d0, d1);
    check({nm, ".hack"}, 64'(hk), 64'd0);
    check({nm, ".ack"},  64'(ak), 64'd0);
    check({nm, ".val"},  64'(v),  64'd0);
    check({nm, ".rt"},   64'(rt), 64'd0);
    check({nm, ".d0"},   d0, 64'd0);
    check({nm, ".d1"},   d1, 64'd0);
  endtask

  // Wait for header_ack with val already held; returns cycles since t0, -1 on timeout.
  task automatic wait_hack(input int sel, input int t0, input string nm, output int hl);
    logic hk, ak, v; logic [3:0] rt; logic [63:0] d0, d1;
    hl = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      get_out(sel, hk, ak, v, rt, d0, d1);
      if (hk) begin
        hl = cyc - t0;
        check({nm, ".ack_with_hack"}, 64'(ak), 64'd1);
        break;
      end
    end
    if (hl < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.hack_timeout: got none expected header_ack", nm);
    end
  endtask

  task automatic issue(input int sel, input logic [4:0] q, input logic [2:0] s, input logic [39:0] a,
                       input logic [63:0] d, input string nm, output int t0, output int hl);
    @(posedge clk); #1;
    rq = q; sz = s; addr = a; wd = d;
    set_val(sel, 1'b1);
    t0 = cyc;
    wait_hack(sel, t0, nm, hl);
    @(posedge clk); #1;
    set_val(sel, 1'b0);
  endtask

  task automatic wait_resp(input int sel, input int t0, input string nm, output int rl,
                           output logic [3:0] rt, output logic [63:0] d0, output logic [63:0] d1);
    logic hk, ak, v;
    rl = -1; rt = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      get_out(sel, hk, ak, v, rt, d0, d1);
      if (v) begin rl = cyc - t0; break; end
    end
    if (rl < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.resp_timeout: got none expected response val", nm);
    end
  endtask

  // Called at a negedge inside RESP: pulse req_ack, then expect val low.
  task automatic ack_resp(input int sel, input string nm);
    logic hk, ak, v; logic [3:0] rt; logic [63:0] d0, d1;
    set_rack(sel, 1'b1);
    @(posedge clk); #1;
    set_rack(sel, 1'b0);
    @(negedge clk);
    get_out(sel, hk, ak, v, rt, d0, d1);
    check({nm, ".val_drop"}, 64'(v), 64'd0);
  endtask

  task automatic run_txn(input vec_t t, input string nm);
    int t0, hl, rl; logic [3:0] rt; logic [63:0] d0, d1;
    issue(t.sel, t.q, t.s, t.a, t.d, nm, t0, hl);
    check({nm, ".hack_lat"}, 64'(hl), 64'd1);
    wait_resp(t.sel, t0, nm, rl, rt, d0, d1);
    check({nm, ".resp_lat"}, 64'(rl), 64'(2 + lat_of(t.sel)));
    check({nm, ".rt"}, 64'(rt), 64'(t.rt));
    check({nm, ".d0"}, d0, t.e0);
    check({nm, ".d1"}, d1, t.e1);
    ack_resp(t.sel, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, hl, rl;
    logic hk, ak, v;
    logic [3:0] rt;
    logic [63:0] d0, d1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(posedge clk); #1; nrst = 1'b1;

    // ---------------- vector table ----------------
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h108, 64'hCAFEBABE_DEADBEEF, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h100, 64'h11223344_55667788, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_LOAD,  SZ_DW, 40'h100, 64'h5A5A5A5A_5A5A5A5A, RT_LOAD_RET,
                    64'h11223344_55667788, 64'hCAFEBABE_DEADBEEF});
    tbl.push_back('{0, RQ_IMISS, SZ_LINE, 40'h108, 64'h0, RT_IFILL_RET,
                    64'h11223344_55667788, 64'hCAFEBABE_DEADBEEF});
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h200, 64'h0, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h208, 64'hFFFFFFFF_FFFFFFFF, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h210, 64'h01234567_89ABCDEF, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_DW, 40'h218, 64'h0, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_B,  40'h203, 64'h55555555_AB555555, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_LOAD,  SZ_DW, 40'h200, 64'h0, RT_LOAD_RET,
                    64'h00000000_AB000000, 64'hFFFFFFFF_FFFFFFFF});
    tbl.push_back('{0, RQ_STORE, SZ_H,  40'h20F, 64'h12340000_00000099, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_STORE, SZ_W,  40'h204, 64'h77777777_12345678, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_LOAD,  SZ_DW, 40'h208, 64'h0, RT_LOAD_RET,
                    64'h77777777_AB000000, 64'h12FFFFFF_FFFFFFFF});
    tbl.push_back('{0, RQ_LOAD,  SZ_DW, 40'h210, 64'h0, RT_LOAD_RET, 64'h01234567_89ABCDEF, 64'h0});
    tbl.push_back('{0, 5'b00110, SZ_DW, 40'h100, 64'h0, RT_UNSUP, 64'h0, 64'h0});
    tbl.push_back('{0, RQ_LOAD,  SZ_DW, 40'h100 + 40'(MW * 8), 64'h0,
                    ERR_EN ? RT_ERR : RT_LOAD_RET,
                    ERR_EN ? 64'h0 : 64'h11223344_55667788,
                    ERR_EN ? 64'h0 : 64'hCAFEBABE_DEADBEEF});
    // LATENCY=0 instance
    tbl.push_back('{1, RQ_STORE, SZ_DW, 40'h0, 64'hA0A0A0A0_A0A0A0A0, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{1, RQ_STORE, SZ_DW, 40'h8, 64'hB1B1B1B1_B1B1B1B1, RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{1, 5'b00110, SZ_DW, 40'h0, 64'h0, RT_UNSUP, 64'h0, 64'h0});
    tbl.push_back('{1, RQ_STORE, SZ_DW, 40'(MW * 8), 64'hC2C2C2C2_C2C2C2C2,
                    ERR_EN ? RT_ERR : RT_ST_ACK, 64'h0, 64'h0});
    tbl.push_back('{1, RQ_LOAD,  SZ_DW, 40'h0, 64'h0, RT_LOAD_RET,
                    ERR_EN ? 64'hA0A0A0A0_A0A0A0A0 : 64'hC2C2C2C2_C2C2C2C2, 64'hB1B1B1B1_B1B1B1B1});
    tbl.push_back('{1, RQ_LOAD,  SZ_DW, 40'(MW * 8), 64'h0,
                    ERR_EN ? RT_ERR : RT_LOAD_RET,
                    ERR_EN ? 64'h0 : 64'hC2C2C2C2_C2C2C2C2,
                    ERR_EN ? 64'h0 : 64'hB1B1B1B1_B1B1B1B1});

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // ---------------- response held, second request stalled ----------------
    issue(0, RQ_LOAD, SZ_DW, 40'h100, 64'h0, "hold1", t0, hl);
    check("hold1.hack_lat", 64'(hl), 64'd1);
    wait_resp(0, t0, "hold1", rl, rt, d0, d1);
    check("hold1.resp_lat", 64'(rl), 64'(2 + LAT_A));
    @(posedge clk); #1;
    rq = RQ_LOAD; sz = SZ_DW; addr = 40'h200; wd = 64'h0; val_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      get_out(0, hk, ak, v, rt, d0, d1);
      check($sformatf("hold.val%0d", i),  64'(v),  64'd1);
      check($sformatf("hold.hack%0d", i), 64'(hk), 64'd0);
      check($sformatf("hold.rt%0d", i),   64'(rt), 64'(RT_LOAD_RET));
      check($sformatf("hold.d0_%0d", i),  d0, 64'h11223344_55667788);
      check($sformatf("hold.d1_%0d", i),  d1, 64'hCAFEBABE_DEADBEEF);
    end
    rack_a = 1'b1;
    @(posedge clk); #1;
    rack_a = 1'b0;
    t0 = cyc;
    wait_hack(0, t0, "hold2", hl);
    check("hold2.hack_lat", 64'(hl), 64'd1);
    @(posedge clk); #1; val_a = 1'b0;
    wait_resp(0, t0, "hold2", rl, rt, d0, d1);
    check("hold2.resp_lat", 64'(rl), 64'(2 + LAT_A));
    check("hold2.d0", d0, 64'h77777777_AB000000);
    check("hold2.d1", d1, 64'h12FFFFFF_FFFFFFFF);
    ack_resp(0, "hold2");

    // ---------------- reset during WAIT ----------------
    issue(0, RQ_LOAD, SZ_DW, 40'h100, 64'h0, "rstw", t0, hl);
    nrst = 1'b0;
    @(posedge clk); #1; nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle(0, $sformatf("rstw%0d", i));
    end
    run_txn('{0, RQ_LOAD, SZ_DW, 40'h100, 64'h0, RT_LOAD_RET,
              64'h11223344_55667788, 64'hCAFEBABE_DEADBEEF}, "rstw_reread");

    // ---------------- randomized traffic vs word-array model ----------------
    for (int w = 16'h100; w < 16'h110; w++) begin
      mdl[w] = {$urandom, $urandom};
      run_txn('{0, RQ_STORE, SZ_DW, 40'(w * 8), mdl[w], RT_ST_ACK, 64'h0, 64'h0},
              $sformatf("init%0d", w));
    end
    for (int n = 0; n < 150; n++) begin
      vec_t t;
      int idx, lane, nb, pick;
      logic hi;
      logic [63:0] tmp;
      idx  = 16'h100 + $urandom_range(0, 15);
      lane = $urandom_range(0, 7);
      t.sel = 0;
      t.a   = 40'(idx * 8 + lane);
      if ($urandom_range(0, 3) == 0) t.a = t.a | (40'($urandom_range(1, 255)) << HI_SH);
      pick = $urandom_range(0, 7);
      if (pick < 3)       t.q = RQ_LOAD;
      else if (pick == 3) t.q = RQ_IMISS;
      else if (pick < 7)  t.q = RQ_STORE;
      else begin
        t.q = 5'($urandom);
        if (t.q == RQ_LOAD || t.q == RQ_IMISS || t.q == RQ_STORE) t.q = 5'b00110;
      end
      t.s = 3'($urandom_range(0, 3));
      t.d = {$urandom, $urandom};
      t.e0 = 64'h0; t.e1 = 64'h0;
      hi = (t.a >> HI_SH) != 0;
      if (ERR_EN && hi) begin
        t.rt = RT_ERR;
      end else if (t.q == RQ_LOAD || t.q == RQ_IMISS) begin
        t.rt = (t.q == RQ_LOAD) ? RT_LOAD_RET : RT_IFILL_RET;
        t.e0 = mdl[idx & ~1];
        t.e1 = mdl[idx | 1];
      end else if (t.q == RQ_STORE) begin
        t.rt = RT_ST_ACK;
        nb = (t.s == SZ_B) ? 1 : (t.s == SZ_H) ? 2 : (t.s == SZ_W) ? 4 : 8;
        tmp = mdl[idx];
        for (int b = lane; b < lane + nb && b < 8; b++) tmp[8*b +: 8] = t.d[8*b +: 8];
        mdl[idx] = tmp;
      end else begin
        t.rt = RT_UNSUP;
      end
      run_txn(t, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
